// File: rtl/systolic_mm_n.sv
// N x N output-stationary systolic matrix multiplier: C = A * B over a streamed inner dimension.
// A columns and B rows arrive one per beat; skew, saturation and a registered read port are internal.
module systolic_mm_n #(
   parameter int unsigned N    = 4,
   parameter int unsigned DW   = 16,
   parameter int unsigned KW   = 8,
   parameter int unsigned FRAC = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [KW-1:0]          k_len,
   input  logic                   a_valid,
   output logic                   a_ready,
   input  logic [N*DW-1:0]        a_data,
   input  logic [N*DW-1:0]        b_data,
   output logic                   busy,
   output logic                   done,
   input  logic [$clog2(N*N)-1:0] res_radr,
   output logic [DW-1:0]          res_rdata,
   output logic                   res_sat,
   output logic                   sat_any
);

   localparam int unsigned CW = $clog2(2*N-1);
   localparam logic signed [2*DW:0] SMAX = $signed({{(DW+2){1'b0}}, {(DW-1){1'b1}}});
   localparam logic signed [2*DW:0] SMIN = $signed({{(DW+2){1'b1}}, {(DW-1){1'b0}}});

   typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

   state_e        state_q, state_d;
   logic [KW-1:0] beat_q, beat_d;
   logic [CW-1:0] drain_q, drain_d;
   logic          clear;
   logic          beat;

   // Tagged operands: bit DW is the valid tag, bits DW-1:0 the data.
   logic [DW:0]    a_edge [N];
   logic [DW:0]    b_edge [N];
   logic [DW:0]    a_out  [N][N];
   logic [DW:0]    b_out  [N][N];
   logic [DW-1:0]  acc_w  [N*N];
   logic [N*N-1:0] sat_w;
   logic           addr_ok;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      drain_d = drain_q;
      clear   = 1'b0;
      beat    = 1'b0;
      a_ready = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               clear = 1'b1;
               if (k_len == '0) begin
                  state_d = StDone;
               end else begin
                  beat_d  = k_len;
                  state_d = StFeed;
               end
            end
         end
         StFeed: begin
            a_ready = 1'b1;
            busy    = 1'b1;
            beat    = a_valid;
            if (a_valid) begin
               beat_d = beat_q - KW'(1);
               if (beat_q == KW'(1)) begin
                  drain_d = CW'(2*N-2);
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            busy = 1'b1;
            if (drain_q == '0) state_d = StDone;
            else drain_d = drain_q - CW'(1);
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         beat_q  <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         drain_q <= drain_d;
      end
   end

   // Row gi of A and column gi of B are delayed gi cycles before entering the array.
   for (genvar gi = 0; gi < N; gi++) begin : g_skew
      logic [DW:0] a_inj, b_inj;
      assign a_inj = beat ? {1'b1, a_data[gi*DW +: DW]} : '0;
      assign b_inj = beat ? {1'b1, b_data[gi*DW +: DW]} : '0;
      if (gi == 0) begin : g_direct
         assign a_edge[gi] = a_inj;
         assign b_edge[gi] = b_inj;
      end else begin : g_delay
         logic [DW:0] a_sk_q [gi];
         logic [DW:0] b_sk_q [gi];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int d = 0; d < gi; d++) begin
                  a_sk_q[d] <= '0;
                  b_sk_q[d] <= '0;
               end
            end else begin
               a_sk_q[0] <= a_inj;
               b_sk_q[0] <= b_inj;
               for (int d = 1; d < gi; d++) begin
                  a_sk_q[d] <= a_sk_q[d-1];
                  b_sk_q[d] <= b_sk_q[d-1];
               end
            end
         end
         assign a_edge[gi] = a_sk_q[gi-1];
         assign b_edge[gi] = b_sk_q[gi-1];
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_pe
         logic [DW:0]              a_q, b_q, a_nxt, b_nxt;
         logic signed [DW-1:0]     acc_q;
         logic                     sat_q;
         logic signed [2*DW-1:0]   a_ext, b_ext, prod, prod_sh;
         logic signed [2*DW:0]     sum;

         if (gj == 0) begin : g_a_left
            assign a_nxt = a_edge[gi];
         end else begin : g_a_shift
            assign a_nxt = a_out[gi][gj-1];
         end
         if (gi == 0) begin : g_b_top
            assign b_nxt = b_edge[gj];
         end else begin : g_b_shift
            assign b_nxt = b_out[gi-1][gj];
         end

         assign a_ext   = $signed({{DW{a_q[DW-1]}}, a_q[DW-1:0]});
         assign b_ext   = $signed({{DW{b_q[DW-1]}}, b_q[DW-1:0]});
         assign prod    = a_ext * b_ext;
         assign prod_sh = prod >>> FRAC;
         assign sum     = $signed({{(DW+1){acc_q[DW-1]}}, acc_q})
                        + $signed({prod_sh[2*DW-1], prod_sh});

         always_ff @(posedge clk) begin
            if (rst) begin
               a_q   <= '0;
               b_q   <= '0;
               acc_q <= '0;
               sat_q <= 1'b0;
            end else begin
               a_q <= a_nxt;
               b_q <= b_nxt;
               if (clear) begin
                  acc_q <= '0;
                  sat_q <= 1'b0;
               end else if (a_q[DW] && b_q[DW]) begin
                  if (sum > SMAX) begin
                     acc_q <= SMAX[DW-1:0];
                     sat_q <= 1'b1;
                  end else if (sum < SMIN) begin
                     acc_q <= SMIN[DW-1:0];
                     sat_q <= 1'b1;
                  end else begin
                     acc_q <= sum[DW-1:0];
                  end
               end
            end
         end

         assign a_out[gi][gj]    = a_q;
         assign b_out[gi][gj]    = b_q;
         assign acc_w[gi*N + gj] = acc_q;
         assign sat_w[gi*N + gj] = sat_q;
      end
   end

   assign addr_ok = 32'(res_radr) < N*N;

   always_ff @(posedge clk) begin
      if (rst) begin
         res_rdata <= '0;
         res_sat   <= 1'b0;
         sat_any   <= 1'b0;
      end else begin
         sat_any <= clear ? 1'b0 : |sat_w;
         if (busy || !addr_ok) begin
            res_rdata <= '0;
            res_sat   <= 1'b0;
         end else begin
            res_rdata <= acc_w[res_radr];
            res_sat   <= sat_w[res_radr];
         end
      end
   end

endmodule
